ysyx_24100027_ifu: RTL

Instruction fetch unit; it is the supplier side of the core's pc/inst/npc interface.
- Owns the architectural PC register.
- Fetches each instruction from instruction memory over a valid/ready request channel and a valid response channel.
- Presents pc/inst to the single-cycle core and holds them stable until the core commits.
- Loads the core's npc on commit.
- Sits between the core and the instruction SRAM/bus bridge.

---
 rtl/ysyx_24100027_ifu_pkg.sv | 13 +
 rtl/ysyx_24100027_ifu.sv | 109 ++++++++++
 2 files changed

// File: rtl/ysyx_24100027_ifu_pkg.sv
// ysyx_24100027_ifu_pkg: shared FSM encodings, fault cause codes and reset PC for the fetch unit
package ysyx_24100027_ifu_pkg;
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_e;
  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_ACCESS   = 2'b01;
  localparam logic [1:0] FC_MISALIGN = 2'b10;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/ysyx_24100027_ifu.sv
// ysyx_24100027_ifu: instruction fetch unit, owns the PC and supplies pc/inst to a single-cycle core
module ysyx_24100027_ifu
  import ysyx_24100027_ifu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  input  logic            commit,
  input  logic [XLEN-1:0] npc,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic [XLEN-1:0] fault_pc,
  output logic [31:0]     retired_cnt
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, inst_q, inst_d, fault_pc_q, fault_pc_d;
  logic            req_valid_q, req_valid_d, inst_valid_q, inst_valid_d, fault_q, fault_d;
  logic [1:0]      fault_cause_q, fault_cause_d;
  logic [31:0]     retired_cnt_q, retired_cnt_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    inst_valid_d  = inst_valid_q;
    fault_d       = fault_q;
    fault_cause_d = fault_cause_q;
    fault_pc_d    = fault_pc_q;
    retired_cnt_d = retired_cnt_q;
    unique case (state_q)
      S_REQ: if (req_valid_q && imem_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid && imem_rsp_err) begin
          fault_d       = 1'b1;
          fault_cause_d = FC_ACCESS;
          fault_pc_d    = pc_q;
          state_d       = S_FAULT;
        end else if (imem_rsp_valid) begin
          inst_d       = imem_rsp_data;
          inst_valid_d = 1'b1;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (commit) begin
          retired_cnt_d = retired_cnt_q + 32'd1;
          inst_valid_d  = 1'b0;
          if (npc[1:0] == 2'b00) begin
            pc_d    = npc;
            state_d = S_REQ;
          end else begin
            fault_d       = 1'b1;
            fault_cause_d = FC_MISALIGN;
            fault_pc_d    = npc;
            state_d       = S_FAULT;
          end
        end
      end
      S_FAULT: state_d = S_FAULT;
    endcase
    // registered so the request appears the cycle after reset release or commit
    req_valid_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      inst_q        <= '0;
      req_valid_q   <= 1'b0;
      inst_valid_q  <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= FC_NONE;
      fault_pc_q    <= '0;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      req_valid_q   <= req_valid_d;
      inst_valid_q  <= inst_valid_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      fault_pc_q    <= fault_pc_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign inst_valid     = inst_valid_q;
  assign fault          = fault_q;
  assign fault_cause    = fault_cause_q;
  assign fault_pc       = fault_pc_q;
  assign retired_cnt    = retired_cnt_q;
endmodule
